// File: rtl/morty_idu.sv
// Decode/issue stage for the morty integer datapath: RV32I ALU decode into a
// two-entry output/skid buffer so that if_ready comes straight from a flop.
module morty_idu #(
    parameter int XLEN         = 32,
    parameter bit RESET_PC_NOP = 1'b0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            if_valid,
    output logic            if_ready,
    input  logic [31:0]     if_instr,
    input  logic [31:0]     if_pc,
    output logic [4:0]      rs1_addr,
    output logic [4:0]      rs2_addr,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    output logic            ex_valid,
    input  logic            ex_ready,
    output logic [XLEN-1:0] ex_port_a,
    output logic [XLEN-1:0] ex_port_b,
    output logic [3:0]      ex_alu_op,
    output logic [4:0]      ex_rd,
    output logic            ex_rd_we,
    output logic            ex_illegal
);
    // state | meaning
    // EMPTY | no entry held
    // ONE   | output register valid
    // TWO   | output register and skid register valid
    typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;

    typedef struct packed {
        logic [XLEN-1:0] port_a;
        logic [XLEN-1:0] port_b;
        logic [3:0]      alu_op;
        logic [4:0]      rd;
        logic            rd_we;
        logic            illegal;
    } entry_t;

    localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_AND = 4'd2, OP_OR = 4'd3,
                           OP_XOR = 4'd4, OP_SLL = 4'd5, OP_SRA = 4'd6, OP_SRL = 4'd7,
                           OP_SLT = 4'd8, OP_SLTU = 4'd9;

    state_t state_q, state_nxt;
    entry_t out_q, skid_q, dec;
    logic   if_ready_q;
    logic   accept, issue, out_ld, out_from_skid, skid_ld;

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [XLEN-1:0] rs1_val, rs2_val, imm_i, imm_u;
    logic            ill;

    assign rs1_addr = if_instr[19:15];
    assign rs2_addr = if_instr[24:20];
    assign opcode   = if_instr[6:0];
    assign funct3   = if_instr[14:12];
    assign funct7   = if_instr[31:25];
    assign rs1_val  = (rs1_addr == 5'd0) ? '0 : rs1_data;
    assign rs2_val  = (rs2_addr == 5'd0) ? '0 : rs2_data;
    assign imm_i    = {{(XLEN-12){if_instr[31]}}, if_instr[31:20]};
    assign imm_u    = {if_instr[31:12], 12'b0};

    always_comb begin
        dec         = '0;
        dec.rd      = if_instr[11:7];
        ill         = 1'b0;
        unique case (opcode)
            7'h33: begin
                dec.port_a = rs1_val;
                dec.port_b = rs2_val;
                if (funct7 == 7'h00) begin
                    unique case (funct3)
                        3'd0: dec.alu_op = OP_ADD;
                        3'd1: dec.alu_op = OP_SLL;
                        3'd2: dec.alu_op = OP_SLT;
                        3'd3: dec.alu_op = OP_SLTU;
                        3'd4: dec.alu_op = OP_XOR;
                        3'd5: dec.alu_op = OP_SRL;
                        3'd6: dec.alu_op = OP_OR;
                        default: dec.alu_op = OP_AND;
                    endcase
                end else if (funct7 == 7'h20 && funct3 == 3'd0) begin
                    dec.alu_op = OP_SUB;
                end else if (funct7 == 7'h20 && funct3 == 3'd5) begin
                    dec.alu_op = OP_SRA;
                end else begin
                    ill = 1'b1;
                end
            end
            7'h13: begin
                dec.port_a = rs1_val;
                dec.port_b = imm_i;
                unique case (funct3)
                    3'd0: dec.alu_op = OP_ADD;
                    3'd2: dec.alu_op = OP_SLT;
                    3'd3: dec.alu_op = OP_SLTU;
                    3'd4: dec.alu_op = OP_XOR;
                    3'd6: dec.alu_op = OP_OR;
                    3'd7: dec.alu_op = OP_AND;
                    3'd1: begin
                        dec.port_b = {{(XLEN-5){1'b0}}, if_instr[24:20]};
                        dec.alu_op = OP_SLL;
                        ill        = (funct7 != 7'h00);
                    end
                    default: begin
                        dec.port_b = {{(XLEN-5){1'b0}}, if_instr[24:20]};
                        dec.alu_op = (funct7 == 7'h20) ? OP_SRA : OP_SRL;
                        ill        = (funct7 != 7'h00) && (funct7 != 7'h20);
                    end
                endcase
            end
            7'h37: begin
                dec.port_b = imm_u;
            end
            7'h17: begin
                dec.port_a = if_pc;
                dec.port_b = imm_u;
            end
            default: ill = 1'b1;
        endcase
        dec.rd_we = !ill && (dec.rd != 5'd0);
        // Illegal encodings carry no operands; the NOP variant also hides the flag.
        if (ill) begin
            dec.port_a  = '0;
            dec.port_b  = '0;
            dec.alu_op  = OP_ADD;
            dec.rd_we   = 1'b0;
            dec.illegal = !RESET_PC_NOP;
            if (RESET_PC_NOP)
                dec.rd = 5'd0;
        end
    end

    assign accept = if_valid && if_ready_q;
    assign issue  = (state_q != EMPTY) && ex_ready;

    always_comb begin
        state_nxt     = state_q;
        out_ld        = 1'b0;
        out_from_skid = 1'b0;
        skid_ld       = 1'b0;
        unique case (state_q)
            EMPTY: begin
                if (accept) begin
                    state_nxt = ONE;
                    out_ld    = 1'b1;
                end
            end
            ONE: begin
                if (accept && !issue) begin
                    state_nxt = TWO;
                    skid_ld   = 1'b1;
                end else if (accept && issue) begin
                    out_ld    = 1'b1;
                end else if (issue) begin
                    state_nxt = EMPTY;
                end
            end
            default: begin
                if (issue) begin
                    state_nxt     = ONE;
                    out_ld        = 1'b1;
                    out_from_skid = 1'b1;
                end
            end
        endcase
        if (flush) begin
            state_nxt     = EMPTY;
            out_ld        = 1'b0;
            out_from_skid = 1'b0;
            skid_ld       = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= EMPTY;
            if_ready_q <= 1'b1;
            out_q      <= '0;
            skid_q     <= '0;
        end else begin
            state_q    <= state_nxt;
            if_ready_q <= (state_nxt != TWO);
            if (out_ld)
                out_q <= out_from_skid ? skid_q : dec;
            if (skid_ld)
                skid_q <= dec;
        end
    end

    assign if_ready   = if_ready_q;
    assign ex_valid   = (state_q != EMPTY);
    assign ex_port_a  = out_q.port_a;
    assign ex_port_b  = out_q.port_b;
    assign ex_alu_op  = out_q.alu_op;
    assign ex_rd      = out_q.rd;
    assign ex_rd_we   = out_q.rd_we;
    assign ex_illegal = out_q.illegal;
endmodule

// File: tb/tb_morty_idu.sv
// Directed bench for morty_idu: decode vectors, skid-buffer streaming, flush and async reset.
module tb_morty_idu;
    logic        clk = 1'b0;
    logic        rst_n, flush, if_valid, if_ready, ex_valid, ex_ready;
    logic [31:0] if_instr, if_pc, rs1_data, rs2_data, ex_port_a, ex_port_b;
    logic [4:0]  rs1_addr, rs2_addr, ex_rd;
    logic [3:0]  ex_alu_op;
    logic        ex_rd_we, ex_illegal;

    int n_chk = 0;
    int n_err = 0;

    morty_idu #(.XLEN(32), .RESET_PC_NOP(1'b0)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr), .if_pc(if_pc),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(rs1_data), .rs2_data(rs2_data),
        .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_port_a(ex_port_a), .ex_port_b(ex_port_b),
        .ex_alu_op(ex_alu_op), .ex_rd(ex_rd), .ex_rd_we(ex_rd_we), .ex_illegal(ex_illegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one instruction, capture it, then check the issued fields.
    task automatic single(input string tag, input logic [31:0] instr, input logic [31:0] pc,
                          input logic [31:0] r1, input logic [31:0] r2,
                          input logic [31:0] a, input logic [31:0] b, input logic [3:0] op,
                          input logic [4:0] rd, input logic we, input logic ill);
        if_instr = instr; if_pc = pc; rs1_data = r1; rs2_data = r2; if_valid = 1'b1;
        step();
        if_valid = 1'b0;
        chk({tag, ".valid"}, {31'b0, ex_valid}, 32'd1);
        chk({tag, ".a"}, ex_port_a, a);
        chk({tag, ".b"}, ex_port_b, b);
        chk({tag, ".op"}, {28'b0, ex_alu_op}, {28'b0, op});
        if (!ill) chk({tag, ".rd"}, {27'b0, ex_rd}, {27'b0, rd});
        chk({tag, ".we"}, {31'b0, ex_rd_we}, {31'b0, we});
        chk({tag, ".ill"}, {31'b0, ex_illegal}, {31'b0, ill});
        step();
    endtask

    logic [31:0] stream [4];
    int in_idx, out_idx;

    initial begin
        rst_n = 1'b0; flush = 1'b0; if_valid = 1'b0; ex_ready = 1'b1;
        if_instr = '0; if_pc = '0; rs1_data = '0; rs2_data = '0;
        for (int i = 0; i < 4; i++)
            stream[i] = ((i + 1) << 20) | ((i + 1) << 7) | 32'h13;  // addi x(i+1),x0,i+1
        step();
        chk("rst.if_ready", {31'b0, if_ready}, 32'd1);
        chk("rst.ex_valid", {31'b0, ex_valid}, 32'd0);
        chk("rst.a", ex_port_a, 32'd0);
        chk("rst.b", ex_port_b, 32'd0);
        chk("rst.op_rd_we_ill", {22'b0, ex_alu_op, ex_rd, ex_rd_we, ex_illegal}, 32'd0);
        #2 rst_n = 1'b1;
        step();

        single("addi", 32'h00500093, 32'h0, 32'hDEAD_BEEF, 32'h0, 32'd0, 32'd5, 4'd0, 5'd1, 1'b1, 1'b0);
        single("sub",  32'h402081B3, 32'h0, 32'd10, 32'd3, 32'd10, 32'd3, 4'd1, 5'd3, 1'b1, 1'b0);
        single("add",  32'h002081B3, 32'h0, 32'd10, 32'd3, 32'd10, 32'd3, 4'd0, 5'd3, 1'b1, 1'b0);
        single("or",   32'h0020E1B3, 32'h0, 32'd6, 32'd9, 32'd6, 32'd9, 4'd3, 5'd3, 1'b1, 1'b0);
        single("srai", 32'h40335293, 32'h0, 32'h8000_0000, 32'h0, 32'h8000_0000, 32'd3, 4'd6, 5'd5, 1'b1, 1'b0);
        single("srai_bad", 32'h20335293, 32'h0, 32'h8000_0000, 32'h0, 32'd0, 32'd0, 4'd0, 5'd5, 1'b0, 1'b1);
        single("lui",  32'h123453B7, 32'h0, 32'h5555, 32'h0, 32'd0, 32'h1234_5000, 4'd0, 5'd7, 1'b1, 1'b0);
        single("auipc", 32'h00001417, 32'h100, 32'h0, 32'h0, 32'h100, 32'h1000, 4'd0, 5'd8, 1'b1, 1'b0);
        single("load_ill", 32'h0000A083, 32'h0, 32'h7, 32'h0, 32'd0, 32'd0, 4'd0, 5'd1, 1'b0, 1'b1);
        single("addi_neg", 32'hFFF00113, 32'h0, 32'h0, 32'h0, 32'd0, 32'hFFFF_FFFF, 4'd0, 5'd2, 1'b1, 1'b0);

        // Stream of four with EXU stalled for the first three cycles.
        in_idx = 0; out_idx = 0;
        for (int cyc = 0; cyc < 12; cyc++) begin
            ex_ready = (cyc >= 3);
            if_valid = (in_idx < 4);
            if_instr = (in_idx < 4) ? stream[in_idx] : 32'h0;
            if (cyc == 2) begin
                chk("stream.if_ready_full", {31'b0, if_ready}, 32'd0);
                chk("stream.ex_valid_full", {31'b0, ex_valid}, 32'd1);
                chk("stream.stall_hold_b", ex_port_b, 32'd1);
            end
            if (ex_valid && ex_ready) begin
                if (out_idx < 4) begin
                    chk("stream.order_b", ex_port_b, out_idx + 1);
                    chk("stream.order_rd", {27'b0, ex_rd}, out_idx + 1);
                end
                out_idx++;
            end
            if (if_valid && if_ready) in_idx++;
            step();
        end
        if_valid = 1'b0;
        chk("stream.issued", out_idx, 32'd4);
        chk("stream.drained", {31'b0, ex_valid}, 32'd0);

        // Flush while full with an offered instruction.
        ex_ready = 1'b0;
        if_valid = 1'b1; if_instr = stream[0]; step();
        if_instr = stream[1]; step();
        chk("flush.pre_full", {31'b0, if_ready}, 32'd0);
        if_instr = stream[2]; flush = 1'b1; step();
        flush = 1'b0; if_valid = 1'b0;
        chk("flush.two.ex_valid", {31'b0, ex_valid}, 32'd0);
        chk("flush.two.if_ready", {31'b0, if_ready}, 32'd1);
        ex_ready = 1'b1;
        step(); step();
        chk("flush.no_stale", {31'b0, ex_valid}, 32'd0);

        // Flush in ONE discards a same-cycle accept.
        ex_ready = 1'b0;
        if_valid = 1'b1; if_instr = stream[0]; step();
        if_instr = stream[1]; flush = 1'b1; step();
        flush = 1'b0; if_valid = 1'b0;
        chk("flush.one.ex_valid", {31'b0, ex_valid}, 32'd0);
        step();
        chk("flush.one.discard", {31'b0, ex_valid}, 32'd0);

        // Asynchronous reset mid-cycle with an entry held.
        if_valid = 1'b1; if_instr = stream[3]; step();
        if_valid = 1'b0;
        chk("areset.pre_valid", {31'b0, ex_valid}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("areset.ex_valid", {31'b0, ex_valid}, 32'd0);
        chk("areset.b", ex_port_b, 32'd0);
        chk("areset.rd", {27'b0, ex_rd}, 32'd0);
        chk("areset.if_ready", {31'b0, if_ready}, 32'd1);
        step();
        #2 rst_n = 1'b1;
        step();
        ex_ready = 1'b1;
        single("post_reset", 32'h00500093, 32'h0, 32'h0, 32'h0, 32'd0, 32'd5, 4'd0, 5'd1, 1'b1, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/morty_idu.md
Name: morty_idu

Overview:
- Decode/issue stage for the morty integer datapath; it is the producer side of the EXU operand/opcode interface.
- Accepts fetched RV32I instructions over a valid/ready handshake and reads rs1/rs2 from the register file.
- Produces port_a, port_b, a 4-bit ALU opcode and writeback control in a registered output stage.
- Holds decoded results in a 2-entry skid buffer so the fetch-side ready is fully registered.

Parameters:
- XLEN, 32, datapath width; only 32 is supported.
- RESET_PC_NOP, 0, when 1, illegal instructions are issued as ADD x0 with ex_illegal=0 instead of being flagged.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous pipeline flush
- if_valid  in  1  fetch presents an instruction
- if_ready  out  1  stage can accept (registered)
- if_instr  in  32  instruction word
- if_pc  in  32  instruction address
- rs1_addr  out  5  regfile read address; equals if_instr[19:15]
- rs2_addr  out  5  regfile read address; equals if_instr[24:20]
- rs1_data  in  32  combinational regfile read data
- rs2_data  in  32  combinational regfile read data
- ex_valid  out  1  issued entry valid
- ex_ready  in  1  EXU consumes the entry
- ex_port_a  out  32  ALU operand A
- ex_port_b  out  32  ALU operand B
- ex_alu_op  out  4  ALU opcode
- ex_rd  out  5  destination register
- ex_rd_we  out  1  writeback enable
- ex_illegal  out  1  unsupported or invalid encoding

Behaviour:
- ALU opcode encoding: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRA, 7 SRL, 8 SLT, 9 SLTU.
- Handshakes:
  - Accept when if_valid && if_ready.
  - Issue completes when ex_valid && ex_ready.
- Decode (combinational, captured on accept):
  - OP (0x33): A=rs1, B=rs2.
    - funct7=0x00: funct3 selects ADD/SLL/SLT/SLTU/XOR/SRL/OR/AND.
    - funct7=0x20: allowed only for funct3 0 (SUB) and 5 (SRA).
    - Any other funct7/funct3 combination is illegal.
  - OP-IMM (0x13): A=rs1, B=sign-extended imm[31:20].
    - Shift immediates (funct3 1 or 5): B={27'b0, instr[24:20]}.
    - SLLI requires funct7=0x00.
    - SRLI requires funct7=0x00; SRAI requires funct7=0x20; otherwise illegal.
  - LUI (0x37): A=0, B={instr[31:12],12'b0}, ADD.
  - AUIPC (0x17): A=if_pc, B={instr[31:12],12'b0}, ADD.
  - Any other opcode: ex_illegal=1, alu_op=0, A=B=0, rd_we=0.
- Register reads and writeback:
  - A read of x0 is forced to 0 regardless of rs1_data/rs2_data.
  - ex_rd_we = legal && (rd != 0).
- Buffer FSM states: EMPTY (0 entries), ONE (output register valid), TWO (output plus skid valid).
  - EMPTY: accept -> ONE.
  - ONE:
    - accept && !issue -> TWO, with the new entry written to skid.
    - accept && issue -> ONE, with the new entry written to output.
    - issue only -> EMPTY.
  - TWO:
    - issue -> ONE; the skid entry moves to the output register in the same edge.
    - Nothing is accepted in TWO.
  - if_ready = (state != TWO), registered from next-state.
  - ex_valid = (state != EMPTY).
  - Output fields are stable while ex_valid && !ex_ready.
- Latency: 1 cycle from accept to ex_valid when the output register is free; throughput is 1 per cycle.
- Flush:
  - Has priority over everything: next state is EMPTY, and any accept in that cycle is discarded.
  - if_ready=1 next cycle.
  - An issue in the flush cycle still counts for the EXU.
- Reset: state EMPTY, if_ready=1, ex_valid=0; all ex_* data outputs are 0.
  - Reset asserted mid-transfer drops all entries immediately.
- Ordering is strictly FIFO; entries are never dropped except by flush or reset.

Test Plan:
- Reset, then if_instr=0x00500093 (addi x1,x0,5), ex_ready=1 -> next cycle ex_valid=1, A=0, B=5, op=0, rd=1, rd_we=1.
- 0x402081B3 (sub x3,x1,x2), rs1_data=10, rs2_data=3 -> A=10, B=3, op=1, rd=3; a second test with 0x002081B3 -> op=0.
- 0x40335293 (srai x5,x6,3), rs1_data=0x80000000 -> op=6, B=3. Negative case: 0x20335293 (bad funct7) -> ex_illegal=1, rd_we=0.
- 0x123453B7 (lui) -> A=0, B=0x12345000. 0x00001417 (auipc), pc=0x100 -> A=0x100, B=0x1000, op=0.
- Back-to-back stream of 4 instructions with ex_ready=0 for 3 cycles -> state TWO and if_ready=0 after 2 accepts. On release, all 4 issue in order with no loss or duplication.
- Flush in state TWO with if_valid=1 -> ex_valid=0 and if_ready=1 next cycle, with no stale entry issued. Asynchronous rst_n pulse mid-stream -> outputs 0 immediately.
